// File: rtl/scroll_step_scheduler.sv
// rtl/scroll_step_scheduler.sv - per-frame parallax layer step scheduler
// Grants per-layer LFSR steps to a shared step unit and defers line reloads past in-flight steps.
module scroll_step_scheduler #(
  parameter int NUM_LAYERS = 4,
  parameter int DIV_W      = 3,
  parameter int LAYER_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        frame_tick,
  input  logic                        line_tick,
  input  logic [NUM_LAYERS*DIV_W-1:0] layer_div,
  output logic                        step_req,
  output logic [LAYER_W-1:0]          step_layer,
  input  logic                        step_ack,
  output logic                        line_reload,
  output logic                        busy,
  output logic                        overrun,
  output logic [NUM_LAYERS-1:0]       pending
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        cnt_q [NUM_LAYERS];
  logic [DIV_W-1:0]        cnt_d [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]   pending_q, pending_d;
  logic [NUM_LAYERS-1:0]   new_bits, clr_bits;
  logic [LAYER_W-1:0]      step_layer_q, step_layer_d;
  logic                    overrun_q, overrun_d;
  logic                    defer_q, defer_d;
  logic                    line_reload_q, line_reload_d;
  logic                    tick;

  function automatic logic [LAYER_W-1:0] lowest(input logic [NUM_LAYERS-1:0] v);
    lowest = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (v[i]) lowest = LAYER_W'(i);
    end
  endfunction

  assign busy = (state_q == GRANT) | (pending_q != '0);

  always_comb begin
    tick          = frame_tick & enable;
    cnt_d         = cnt_q;
    new_bits      = '0;
    clr_bits      = '0;
    state_d       = state_q;
    step_layer_d  = step_layer_q;
    defer_d       = defer_q;
    line_reload_d = 1'b0;

    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (tick) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i]    = layer_div[i*DIV_W +: DIV_W];
          new_bits[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
      clr_bits[i] = (state_q == GRANT) && step_ack && (step_layer_q == LAYER_W'(i));
    end

    // A tick re-setting the bit being acked keeps it set: that is the new frame's step.
    pending_d = (pending_q & ~clr_bits) | new_bits;
    overrun_d = overrun_q | (tick & busy);

    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          state_d      = GRANT;
          step_layer_d = lowest(pending_q);
        end
      end
      GRANT: begin
        if (step_ack) begin
          if (pending_d != '0) step_layer_d = lowest(pending_d);
          else                 state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reloads wait until nothing is queued or in flight; repeated requests collapse.
    if (!busy) begin
      line_reload_d = line_tick | defer_q;
      defer_d       = 1'b0;
    end else if (line_tick) begin
      defer_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      step_layer_q  <= '0;
      overrun_q     <= 1'b0;
      defer_q       <= 1'b0;
      line_reload_q <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      step_layer_q  <= step_layer_d;
      overrun_q     <= overrun_d;
      defer_q       <= defer_d;
      line_reload_q <= line_reload_d;
      for (int i = 0; i < NUM_LAYERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign step_req    = (state_q == GRANT);
  assign step_layer  = step_layer_q;
  assign line_reload = line_reload_q;
  assign overrun     = overrun_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_scroll_step_scheduler.sv
// tb/tb_scroll_step_scheduler.sv - self-checking bench for scroll_step_scheduler
module tb_scroll_step_scheduler;
  localparam int NL = 4;
  localparam int DW = 3;
  localparam int LW = 2;

  logic          clk, rst, enable, frame_tick, line_tick, step_ack;
  logic [NL*DW-1:0] layer_div;
  logic          step_req, line_reload, busy, overrun;
  logic [LW-1:0] step_layer;
  logic [NL-1:0] pending;

  int total = 0;
  int bad   = 0;
  int steps [NL];

  scroll_step_scheduler #(.NUM_LAYERS(NL), .DIV_W(DW), .LAYER_W(LW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick), .line_tick(line_tick),
    .layer_div(layer_div), .step_req(step_req), .step_layer(step_layer), .step_ack(step_ack),
    .line_reload(line_reload), .busy(busy), .overrun(overrun), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick_clk();
    if (step_req && step_ack) steps[step_layer]++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_steps();
    foreach (steps[i]) steps[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; line_tick = 1'b0; step_ack = 1'b0;
    layer_div = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick_clk();
    clear_steps();
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick_clk();
    frame_tick = 1'b0;
  endtask

  task automatic set_div(input int d0, input int d1, input int d2, input int d3);
    layer_div = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; line_tick = 1'b0; step_ack = 1'b0;
    layer_div = '0;
    @(posedge clk);
    #1;
    total++; if (step_req !== 1'b0) begin bad++; $display("FAIL reset_step_req got=%0b exp=0", step_req); end
    total++; if (step_layer !== '0) begin bad++; $display("FAIL reset_step_layer got=%0d exp=0", step_layer); end
    total++; if (line_reload !== 1'b0) begin bad++; $display("FAIL reset_line_reload got=%0b exp=0", line_reload); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    total++; if (pending !== '0) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    rst = 1'b0;
    tick_clk();
  endtask

  task automatic test_divider();
    int exp_cnt [NL] = '{6, 3, 2, 2};
    do_reset();
    set_div(0, 1, 2, 3);
    enable = 1'b1; step_ack = 1'b1;
    pulse_tick();
    total++; if (step_req !== 1'b0) begin bad++; $display("FAIL latency_t1 step_req got=%0b exp=0", step_req); end
    for (int k = 0; k < NL; k++) begin
      tick_clk();
      total++;
      if (step_req !== 1'b1 || step_layer !== LW'(k)) begin
        bad++; $display("FAIL first_frame_order req=%0b layer=%0d exp req=1 layer=%0d", step_req, step_layer, k);
      end
    end
    repeat (8) tick_clk();
    for (int f = 1; f < 6; f++) begin
      pulse_tick();
      repeat (10) tick_clk();
    end
    for (int i = 0; i < NL; i++) begin
      total++;
      if (steps[i] !== exp_cnt[i]) begin
        bad++; $display("FAIL divider_steps layer=%0d got=%0d exp=%0d", i, steps[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_ack_delay();
    do_reset();
    set_div(0, 0, 0, 0);
    enable = 1'b1; step_ack = 1'b0;
    pulse_tick();
    tick_clk();
    for (int k = 0; k < NL; k++) begin
      total++;
      if (step_req !== 1'b1 || step_layer !== LW'(k)) begin
        bad++; $display("FAIL ack_layer req=%0b layer=%0d exp req=1 layer=%0d", step_req, step_layer, k);
      end
      repeat (3) begin
        tick_clk();
        total++;
        if (step_req !== 1'b1 || step_layer !== LW'(k)) begin
          bad++; $display("FAIL ack_hold req=%0b layer=%0d exp req=1 layer=%0d", step_req, step_layer, k);
        end
      end
      step_ack = 1'b1;
      tick_clk();
      step_ack = 1'b0;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ack_busy_drop got=%0b exp=0", busy); end
    total++; if (pending !== '0) begin bad++; $display("FAIL ack_pending got=%b exp=0000", pending); end
    for (int i = 0; i < NL; i++) begin
      total++;
      if (steps[i] !== 1) begin bad++; $display("FAIL ack_steps layer=%0d got=%0d exp=1", i, steps[i]); end
    end
  endtask

  task automatic test_line_defer();
    int bound;
    int pulses;
    do_reset();
    set_div(0, 0, 0, 0);
    enable = 1'b1; step_ack = 1'b0;
    pulse_tick();
    tick_clk();
    for (int c = 0; c < 10; c++) begin
      line_tick = (c == 1 || c == 4 || c == 7);
      tick_clk();
      total++;
      if (line_reload !== 1'b0) begin bad++; $display("FAIL defer_during_grant cycle=%0d got=%0b exp=0", c, line_reload); end
    end
    line_tick = 1'b0;
    step_ack = 1'b1;
    bound = 0;
    while (busy === 1'b1 && bound < 20) begin
      total++;
      if (line_reload !== 1'b0) begin bad++; $display("FAIL defer_while_busy got=%0b exp=0", line_reload); end
      tick_clk();
      bound++;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL defer_busy_timeout got=%0b exp=0", busy); end
    total++; if (line_reload !== 1'b0) begin bad++; $display("FAIL defer_early got=%0b exp=0", line_reload); end
    tick_clk();
    total++; if (line_reload !== 1'b1) begin bad++; $display("FAIL defer_pulse got=%0b exp=1", line_reload); end
    pulses = 0;
    repeat (5) begin
      tick_clk();
      if (line_reload === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL defer_collapse extra=%0d exp=0", pulses); end
    step_ack = 1'b0;
    line_tick = 1'b1;
    tick_clk();
    line_tick = 1'b0;
    total++; if (line_reload !== 1'b1) begin bad++; $display("FAIL idle_reload got=%0b exp=1", line_reload); end
    tick_clk();
    total++; if (line_reload !== 1'b0) begin bad++; $display("FAIL idle_reload_width got=%0b exp=0", line_reload); end
  endtask

  task automatic test_overrun();
    do_reset();
    set_div(1, 1, 1, 0);
    enable = 1'b1; step_ack = 1'b1;
    pulse_tick();
    repeat (8) tick_clk();
    step_ack = 1'b0;
    pulse_tick();
    total++; if (pending !== 4'b1000) begin bad++; $display("FAIL ovr_pending_pre got=%b exp=1000", pending); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre got=%0b exp=0", overrun); end
    repeat (3) tick_clk();
    total++;
    if (step_req !== 1'b1 || step_layer !== 2'd3) begin
      bad++; $display("FAIL ovr_grant req=%0b layer=%0d exp req=1 layer=3", step_req, step_layer);
    end
    pulse_tick();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
    total++; if (pending !== 4'b1111) begin bad++; $display("FAIL ovr_pending_or got=%b exp=1111", pending); end
    total++; if (step_layer !== 2'd3) begin bad++; $display("FAIL ovr_layer_hold got=%0d exp=3", step_layer); end
    step_ack = 1'b1;
    repeat (10) tick_clk();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_drain busy=%0b exp=0", busy); end
    pulse_tick();
    repeat (10) tick_clk();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
  endtask

  task automatic test_enable();
    int sum;
    do_reset();
    set_div(3, 3, 3, 3);
    enable = 1'b1; step_ack = 1'b1;
    pulse_tick();
    repeat (8) tick_clk();
    clear_steps();
    enable = 1'b0;
    repeat (4) begin
      pulse_tick();
      repeat (5) tick_clk();
    end
    sum = 0;
    foreach (steps[i]) sum += steps[i];
    total++; if (sum !== 0) begin bad++; $display("FAIL en_frozen steps=%0d exp=0", sum); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy got=%0b exp=0", busy); end
    enable = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      pulse_tick();
      total++;
      if (pending !== ((t == 4) ? 4'b1111 : 4'b0000)) begin
        bad++; $display("FAIL en_tick%0d pending got=%b exp=%b", t, pending, (t == 4) ? 4'b1111 : 4'b0000);
      end
      repeat (8) tick_clk();
    end
    for (int i = 0; i < NL; i++) begin
      total++;
      if (steps[i] !== 1) begin bad++; $display("FAIL en_steps layer=%0d got=%0d exp=1", i, steps[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_div(2, 0, 0, 2);
    enable = 1'b1; step_ack = 1'b1;
    pulse_tick();
    repeat (8) tick_clk();
    step_ack = 1'b0;
    pulse_tick();
    tick_clk();
    total++; if (pending !== 4'b0110) begin bad++; $display("FAIL mid_pending got=%b exp=0110", pending); end
    pulse_tick();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL mid_overrun got=%0b exp=1", overrun); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (step_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%0b exp=0", step_req); end
    total++; if (pending !== '0) begin bad++; $display("FAIL mid_rst_pending got=%b exp=0000", pending); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%0b exp=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL mid_rst_overrun got=%0b exp=0", overrun); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_steps();
    step_ack = 1'b1;
    pulse_tick();
    repeat (8) tick_clk();
    for (int i = 0; i < NL; i++) begin
      total++;
      if (steps[i] !== 1) begin bad++; $display("FAIL mid_restart layer=%0d got=%0d exp=1", i, steps[i]); end
    end
  endtask

  task automatic test_random();
    int dv [NL];
    int next_step [NL];
    int exp_steps [NL];
    int n;
    logic [NL-1:0] exp_bits;
    do_reset();
    n = 0;
    for (int i = 0; i < NL; i++) begin
      dv[i] = $urandom_range(0, 7);
      next_step[i] = 0;
      exp_steps[i] = 0;
    end
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) dv[$urandom_range(0, NL-1)] = $urandom_range(0, 7);
      set_div(dv[0], dv[1], dv[2], dv[3]);
      enable = ($urandom_range(0, 3) != 0);
      exp_bits = '0;
      if (enable) begin
        for (int i = 0; i < NL; i++) begin
          if (next_step[i] == n) begin
            exp_bits[i] = 1'b1;
            next_step[i] = n + dv[i] + 1;
            exp_steps[i]++;
          end
        end
        n++;
      end
      pulse_tick();
      total++;
      if (pending !== exp_bits) begin bad++; $display("FAIL rnd_pending tick=%0d got=%b exp=%b", t, pending, exp_bits); end
      for (int c = 0; c < 40; c++) begin
        step_ack  = ($urandom_range(0, 3) != 0);
        line_tick = ($urandom_range(0, 7) == 0);
        tick_clk();
        total++;
        if (line_reload === 1'b1 && step_req === 1'b1) begin
          bad++; $display("FAIL rnd_reload_vs_req tick=%0d reload=%0b req=%0b exp reload=0", t, line_reload, step_req);
        end
      end
      step_ack = 1'b0; line_tick = 1'b0;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rnd_drain tick=%0d busy=%0b exp=0", t, busy); end
    end
    for (int i = 0; i < NL; i++) begin
      total++;
      if (steps[i] !== exp_steps[i]) begin
        bad++; $display("FAIL rnd_steps layer=%0d got=%0d exp=%0d", i, steps[i], exp_steps[i]);
      end
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rnd_overrun got=%0b exp=0", overrun); end
  endtask

  initial begin
    clear_steps();
    test_reset();
    test_divider();
    test_ack_delay();
    test_line_defer();
    test_overrun();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
